// File: rtl/seq_detect_ctrl.sv
// seq_detect_ctrl: run controller for a bit-serial pattern detector.
// A start pulse captures the run configuration; during SCAN the block accepts
// bits from a valid/ready stream, flags pattern matches on z, counts matches and
// accepted bits, and ends the run on match limit, bit budget or abort.
// Build option: define SEQ_DETECT_CTRL_NONOVERLAP_EN for non-overlapping
// detection (fill restarts after every match); default is overlapping.
module seq_detect_ctrl #(
   parameter int MAX_LEN = 8,
   parameter int LEN_W   = 4,
   parameter int CNT_W   = 8
) (
   input  logic               clock,
   input  logic               reset,
   input  logic               start,
   input  logic               abort,
   input  logic [MAX_LEN-1:0] pattern,
   input  logic [LEN_W-1:0]   pat_len,
   input  logic [CNT_W-1:0]   max_matches,
   input  logic [CNT_W-1:0]   bit_budget,
   input  logic               x,
   input  logic               x_valid,
   output logic               x_ready,
   output logic               z,
   output logic               busy,
   output logic               done,
   output logic               err,
   output logic [CNT_W-1:0]   match_count,
   output logic [CNT_W-1:0]   bits_seen
);

   typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

   localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(MAX_LEN);

   state_t             state_q;
   // Only MAX_LEN-1 past bits are stored: the incoming bit completes the window.
   logic [MAX_LEN-2:0] hist_q;
   logic [MAX_LEN-1:0] pat_q;
   logic [LEN_W-1:0]   fill_q, len_q;
   logic [CNT_W-1:0]   max_q, budget_q, mcnt_q, bcnt_q;
   logic               z_q, err_q;

   logic [MAX_LEN-1:0] hist_d, mask_d;
   logic [LEN_W-1:0]   fill_sat_d, fill_d;
   logic [CNT_W-1:0]   mcnt_d, bcnt_d;
   logic               accept_d, hit_d, limit_d, len_bad_d;

   // Next history, match detection, counter increments and run-end condition.
   always_comb begin
      accept_d   = (state_q == SCAN) && x_valid;
      hist_d     = {hist_q, x};
      fill_sat_d = (fill_q == LEN_MAX) ? fill_q : fill_q + LEN_W'(1);
      mask_d     = '0;
      for (int i = 0; i < MAX_LEN; i++) begin
         mask_d[i] = (LEN_W'(i) < len_q);
      end
      hit_d = accept_d && (fill_sat_d >= len_q) &&
              (((hist_d ^ pat_q) & mask_d) == '0);
`ifdef SEQ_DETECT_CTRL_NONOVERLAP_EN
      fill_d = hit_d ? '0 : fill_sat_d;
`else
      fill_d = fill_sat_d;
`endif
      // Counters stick at all-ones; a nonzero limit always ends the run first.
      mcnt_d    = (hit_d && !(&mcnt_q)) ? mcnt_q + CNT_W'(1) : mcnt_q;
      bcnt_d    = (accept_d && !(&bcnt_q)) ? bcnt_q + CNT_W'(1) : bcnt_q;
      limit_d   = ((max_q != '0) && (mcnt_d == max_q)) ||
                  ((budget_q != '0) && (bcnt_d == budget_q));
      len_bad_d = (pat_len == '0) || (pat_len > LEN_MAX);
   end

   // Run-control FSM with registered match pulse, error flag and counters.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= IDLE;
         hist_q  <= '0;
         fill_q  <= '0;
         z_q     <= 1'b0;
         err_q   <= 1'b0;
         mcnt_q  <= '0;
         bcnt_q  <= '0;
      end else begin
         z_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (start) begin
                  pat_q    <= pattern;
                  len_q    <= pat_len;
                  max_q    <= max_matches;
                  budget_q <= bit_budget;
                  hist_q   <= '0;
                  fill_q   <= '0;
                  mcnt_q   <= '0;
                  bcnt_q   <= '0;
                  err_q    <= len_bad_d;
                  state_q  <= len_bad_d ? DONE : SCAN;
               end
            end
            SCAN: begin
               if (accept_d) begin
                  hist_q <= hist_d[MAX_LEN-2:0];
                  fill_q <= fill_d;
                  bcnt_q <= bcnt_d;
                  mcnt_q <= mcnt_d;
                  z_q    <= hit_d;
               end
               if ((accept_d && limit_d) || abort) begin
                  state_q <= DONE;
               end
            end
            DONE: begin
               state_q <= IDLE;
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign x_ready     = (state_q == SCAN);
   assign busy        = (state_q == SCAN);
   assign done        = (state_q == DONE);
   assign z           = z_q;
   assign err         = err_q;
   assign match_count = mcnt_q;
   assign bits_seen   = bcnt_q;

endmodule

// File: tb/tb_seq_detect_ctrl.sv
// Directed testbench for seq_detect_ctrl (MAX_LEN=8, LEN_W=4, CNT_W=8).
module tb_seq_detect_ctrl;

   logic       clock = 1'b0;
   logic       reset, start, abort, x, x_valid;
   logic [7:0] pattern;
   logic [3:0] pat_len;
   logic [7:0] max_matches, bit_budget;
   logic       x_ready, z, busy, done, err;
   logic [7:0] match_count, bits_seen;

   int errors = 0;
   int checks = 0;

   seq_detect_ctrl #(.MAX_LEN(8), .LEN_W(4), .CNT_W(8)) dut (
      .clock(clock), .reset(reset), .start(start), .abort(abort),
      .pattern(pattern), .pat_len(pat_len), .max_matches(max_matches),
      .bit_budget(bit_budget), .x(x), .x_valid(x_valid), .x_ready(x_ready),
      .z(z), .busy(busy), .done(done), .err(err),
      .match_count(match_count), .bits_seen(bits_seen)
   );

   always #5 clock = ~clock;

   // Advance one clock; inputs are driven and outputs sampled 1ns after the edge.
   task automatic tick;
      @(posedge clock);
      #1;
   endtask

   task automatic begin_run(input logic [7:0] p, input logic [3:0] l,
                            input logic [7:0] m, input logic [7:0] b);
      pattern = p; pat_len = l; max_matches = m; bit_budget = b;
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic test_reset;
      reset = 1'b1;
      tick();
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got=%b exp=0", busy); end
      checks++; if (x_ready !== 1'b0) begin errors++; $display("FAIL rst_xready got=%b exp=0", x_ready); end
      checks++; if (z !== 1'b0) begin errors++; $display("FAIL rst_z got=%b exp=0", z); end
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL rst_done got=%b exp=0", done); end
      checks++; if (err !== 1'b0) begin errors++; $display("FAIL rst_err got=%b exp=0", err); end
      checks++; if (match_count !== 8'd0) begin errors++; $display("FAIL rst_mcnt got=%0d exp=0", match_count); end
      checks++; if (bits_seen !== 8'd0) begin errors++; $display("FAIL rst_bits got=%0d exp=0", bits_seen); end
      tick();
      reset = 1'b0;
      tick();
   endtask

   task automatic test_overlap;
      logic [7:0] s, ez;
      s = 8'b01101101;  // s[0] is the first bit: 1,0,1,1,0,1,1,0
`ifdef SEQ_DETECT_CTRL_NONOVERLAP_EN
      ez = 8'b00010000;
`else
      ez = 8'b10010000;
`endif
      begin_run(8'b00010110, 4'd5, 8'd0, 8'd8);
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL ovl_busy got=%b exp=1", busy); end
      checks++; if (x_ready !== 1'b1) begin errors++; $display("FAIL ovl_xready got=%b exp=1", x_ready); end
      for (int i = 0; i < 8; i++) begin
         x = s[i]; x_valid = 1'b1;
         tick();
         checks++; if (z !== ez[i]) begin errors++; $display("FAIL ovl_z bit%0d got=%b exp=%b", i + 1, z, ez[i]); end
         checks++; if (done !== (i == 7)) begin errors++; $display("FAIL ovl_done bit%0d got=%b exp=%b", i + 1, done, (i == 7)); end
      end
      x_valid = 1'b0;
`ifdef SEQ_DETECT_CTRL_NONOVERLAP_EN
      checks++; if (match_count !== 8'd1) begin errors++; $display("FAIL ovl_mcnt got=%0d exp=1", match_count); end
`else
      checks++; if (match_count !== 8'd2) begin errors++; $display("FAIL ovl_mcnt got=%0d exp=2", match_count); end
`endif
      checks++; if (bits_seen !== 8'd8) begin errors++; $display("FAIL ovl_bits got=%0d exp=8", bits_seen); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ovl_busy_end got=%b exp=0", busy); end
      tick();
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL ovl_done_once got=%b exp=0", done); end
      checks++; if (bits_seen !== 8'd8) begin errors++; $display("FAIL ovl_bits_hold got=%0d exp=8", bits_seen); end
   endtask

   task automatic test_match_limit;
      logic [7:0] s;
      s = 8'b01101101;
      begin_run(8'b00010110, 4'd5, 8'd1, 8'd0);
      for (int i = 0; i < 8; i++) begin
         x = s[i]; x_valid = 1'b1;
         tick();
         checks++; if (done !== (i == 4)) begin errors++; $display("FAIL lim_done bit%0d got=%b exp=%b", i + 1, done, (i == 4)); end
         checks++; if (x_ready !== (i < 4)) begin errors++; $display("FAIL lim_xready bit%0d got=%b exp=%b", i + 1, x_ready, (i < 4)); end
      end
      x_valid = 1'b0;
      checks++; if (bits_seen !== 8'd5) begin errors++; $display("FAIL lim_bits got=%0d exp=5", bits_seen); end
      checks++; if (match_count !== 8'd1) begin errors++; $display("FAIL lim_mcnt got=%0d exp=1", match_count); end
      tick();
   endtask

   task automatic test_gaps;
      logic [6:0] xs, xv, ez;
      xs = 7'b1111011;  // index 0 first: 1,1,0,1,1,1,1
      xv = 7'b1010101;  // valid on even indices only
      ez = 7'b1000000;
      begin_run(8'b00000011, 4'd2, 8'd0, 8'd0);
      for (int i = 0; i < 7; i++) begin
         x = xs[i]; x_valid = xv[i];
         tick();
         checks++; if (z !== ez[i]) begin errors++; $display("FAIL gap_z cyc%0d got=%b exp=%b", i, z, ez[i]); end
      end
      x_valid = 1'b0;
      checks++; if (bits_seen !== 8'd4) begin errors++; $display("FAIL gap_bits got=%0d exp=4", bits_seen); end
      checks++; if (match_count !== 8'd1) begin errors++; $display("FAIL gap_mcnt got=%0d exp=1", match_count); end
      abort = 1'b1;
      tick();
      abort = 1'b0;
      checks++; if (done !== 1'b1) begin errors++; $display("FAIL gap_done got=%b exp=1", done); end
      tick();
   endtask

   task automatic test_illegal;
      logic [3:0] lens [2];
      lens[0] = 4'd0; lens[1] = 4'd9;
      for (int k = 0; k < 2; k++) begin
         x = 1'b1; x_valid = 1'b1;
         begin_run(8'hFF, lens[k], 8'd0, 8'd0);
         checks++; if (done !== 1'b1) begin errors++; $display("FAIL ill_done len%0d got=%b exp=1", lens[k], done); end
         checks++; if (err !== 1'b1) begin errors++; $display("FAIL ill_err len%0d got=%b exp=1", lens[k], err); end
         checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ill_busy len%0d got=%b exp=0", lens[k], busy); end
         checks++; if (x_ready !== 1'b0) begin errors++; $display("FAIL ill_xready len%0d got=%b exp=0", lens[k], x_ready); end
         tick();
         checks++; if (done !== 1'b0) begin errors++; $display("FAIL ill_done2 len%0d got=%b exp=0", lens[k], done); end
         checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ill_busy2 len%0d got=%b exp=0", lens[k], busy); end
         checks++; if (err !== 1'b1) begin errors++; $display("FAIL ill_errhold len%0d got=%b exp=1", lens[k], err); end
         checks++; if (bits_seen !== 8'd0) begin errors++; $display("FAIL ill_bits len%0d got=%0d exp=0", lens[k], bits_seen); end
      end
      x_valid = 1'b0;
   endtask

   task automatic test_abort;
      logic [3:0] s;
      s = 4'b1101;  // 1,0,1,1
      begin_run(8'b00010110, 4'd5, 8'd0, 8'd0);
      checks++; if (err !== 1'b0) begin errors++; $display("FAIL abt_errclr got=%b exp=0", err); end
      for (int i = 0; i < 3; i++) begin
         x = s[i]; x_valid = 1'b1;
         tick();
      end
      x_valid = 1'b0; abort = 1'b1;
      tick();
      abort = 1'b0;
      checks++; if (done !== 1'b1) begin errors++; $display("FAIL abt_done got=%b exp=1", done); end
      checks++; if (bits_seen !== 8'd3) begin errors++; $display("FAIL abt_bits got=%0d exp=3", bits_seen); end
      tick();
      // Abort coincident with a matching accepted bit: the bit still counts.
      begin_run(8'b00010110, 4'd5, 8'd0, 8'd0);
      for (int i = 0; i < 4; i++) begin
         x = s[i]; x_valid = 1'b1;
         tick();
      end
      x = 1'b0; x_valid = 1'b1; abort = 1'b1;
      tick();
      abort = 1'b0; x_valid = 1'b0;
      checks++; if (done !== 1'b1) begin errors++; $display("FAIL abtx_done got=%b exp=1", done); end
      checks++; if (z !== 1'b1) begin errors++; $display("FAIL abtx_z got=%b exp=1", z); end
      checks++; if (bits_seen !== 8'd5) begin errors++; $display("FAIL abtx_bits got=%0d exp=5", bits_seen); end
      checks++; if (match_count !== 8'd1) begin errors++; $display("FAIL abtx_mcnt got=%0d exp=1", match_count); end
      tick();
   endtask

   task automatic test_start_ignored;
      logic [4:0] s, ez;
      s  = 5'b01101;  // 1,0,1,1,0
      ez = 5'b10000;
      begin_run(8'b00010110, 4'd5, 8'd0, 8'd0);
      for (int i = 0; i < 5; i++) begin
         x = s[i]; x_valid = 1'b1;
         if (i == 2) begin
            start = 1'b1; pattern = 8'b00000011; pat_len = 4'd2;
            max_matches = 8'd1; bit_budget = 8'd1;
         end
         tick();
         start = 1'b0;
         checks++; if (z !== ez[i]) begin errors++; $display("FAIL sti_z bit%0d got=%b exp=%b", i + 1, z, ez[i]); end
         checks++; if (busy !== 1'b1) begin errors++; $display("FAIL sti_busy bit%0d got=%b exp=1", i + 1, busy); end
      end
      x_valid = 1'b0;
      checks++; if (bits_seen !== 8'd5) begin errors++; $display("FAIL sti_bits got=%0d exp=5", bits_seen); end
      abort = 1'b1;
      tick();
      abort = 1'b0;
      tick();
   endtask

   task automatic test_reset_mid;
      begin_run(8'b00000011, 4'd2, 8'd0, 8'd0);
      x = 1'b1; x_valid = 1'b1;
      tick();
      reset = 1'b1;
      tick();
      reset = 1'b0; x_valid = 1'b0;
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rmid_busy got=%b exp=0", busy); end
      checks++; if (x_ready !== 1'b0) begin errors++; $display("FAIL rmid_xready got=%b exp=0", x_ready); end
      checks++; if (z !== 1'b0) begin errors++; $display("FAIL rmid_z got=%b exp=0", z); end
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL rmid_done got=%b exp=0", done); end
      checks++; if (match_count !== 8'd0) begin errors++; $display("FAIL rmid_mcnt got=%0d exp=0", match_count); end
      checks++; if (bits_seen !== 8'd0) begin errors++; $display("FAIL rmid_bits got=%0d exp=0", bits_seen); end
      tick();
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rmid_idle got=%b exp=0", busy); end
   endtask

   task automatic test_saturate;
      begin_run(8'b00000011, 4'd2, 8'd0, 8'd0);
      x = 1'b1; x_valid = 1'b1;
      for (int i = 0; i < 300; i++) tick();
      x_valid = 1'b0;
`ifdef SEQ_DETECT_CTRL_NONOVERLAP_EN
      checks++; if (match_count !== 8'd150) begin errors++; $display("FAIL sat_mcnt got=%0d exp=150", match_count); end
`else
      checks++; if (match_count !== 8'd255) begin errors++; $display("FAIL sat_mcnt got=%0d exp=255", match_count); end
`endif
      checks++; if (bits_seen !== 8'd255) begin errors++; $display("FAIL sat_bits got=%0d exp=255", bits_seen); end
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL sat_busy got=%b exp=1", busy); end
      abort = 1'b1;
      tick();
      abort = 1'b0;
      checks++; if (done !== 1'b1) begin errors++; $display("FAIL sat_done got=%b exp=1", done); end
      tick();
   endtask

   initial begin
      reset = 1'b0; start = 1'b0; abort = 1'b0; x = 1'b0; x_valid = 1'b0;
      pattern = 8'h00; pat_len = 4'd0; max_matches = 8'd0; bit_budget = 8'd0;
      test_reset();
      test_overlap();
      test_match_limit();
      test_gaps();
      test_illegal();
      test_abort();
      test_start_ignored();
      test_reset_mid();
      test_saturate();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
